cpu_icache: RTL and testbench

Direct-mapped instruction cache between the instruction-fetch stage and the backing instruction memory bus. It answers the fetch stage's combinational `imem_addr` lookup with `iin` in the same cycle on a hit. On a miss it raises `stall` and refills the whole line through a req/ack word bus. `stall` is ORed into the fetch stage's stall input by the hazard logic.

---
 rtl/cpu_icache_pkg.sv | 10 +
 rtl/cpu_icache_fill.sv | 58 +++++
 rtl/cpu_icache.sv | 63 ++++++
 tb/tb_cpu_icache.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/cpu_icache_pkg.sv
// cpu_icache_pkg: shared state encoding, default geometry and constants for the instruction cache
package cpu_icache_pkg;
  typedef enum logic {IDLE, FILL} state_t;
  localparam int LINES_DEF = 16;
  localparam int WORDS_DEF = 4;
  localparam int OFF_W = $clog2(WORDS_DEF);
  localparam int IDX_W = $clog2(LINES_DEF);
  localparam int TAG_W = 30 - OFF_W - IDX_W;
  localparam logic [31:0] NOP = 32'h0;
endpackage

// File: rtl/cpu_icache_fill.sv
// cpu_icache_fill: miss/refill sequencer driving the word-read bus and the array write strobes
module cpu_icache_fill import cpu_icache_pkg::*; #(
  parameter int WORDS = WORDS_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       miss,
  input  logic                       inv,
  input  logic                       mem_ack,
  input  logic [29-$clog2(WORDS):0]  line,
  output logic                       idle,
  output logic                       we,
  output logic                       last,
  output logic                       set_valid,
  output logic                       mem_req,
  output logic [31:0]                mem_addr,
  output logic [29-$clog2(WORDS):0]  wr_line,
  output logic [$clog2(WORDS)-1:0]   wr_off
);
  localparam int OW = $clog2(WORDS);
  state_t state;
  logic [OW-1:0] count;
  logic discard;
  assign idle = state == IDLE;
  assign we = state == FILL && mem_ack;
  assign last = we && count == OW'(WORDS - 1);
  // an inv on the final ack must also keep the line invalid
  assign set_valid = last && !discard && !inv;
  assign wr_off = count;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      count <= '0;
      discard <= 1'b0;
      mem_req <= 1'b0;
      mem_addr <= '0;
      wr_line <= '0;
    end else if (idle) begin
      discard <= 1'b0;
      if (miss) begin
        state <= FILL;
        wr_line <= line;
        count <= '0;
        mem_req <= 1'b1;
        mem_addr <= {line, OW'(0), 2'b00};
      end
    end else begin
      if (inv) discard <= 1'b1;
      if (mem_ack) begin
        count <= count + OW'(1);
        mem_addr <= {wr_line, count + OW'(1), 2'b00};
        if (last) begin
          state <= IDLE;
          mem_req <= 1'b0;
        end
      end
    end
endmodule

// File: rtl/cpu_icache.sv
// cpu_icache: direct-mapped instruction cache with combinational hit path and whole-line refill
module cpu_icache import cpu_icache_pkg::*; #(
  parameter int LINES = LINES_DEF,
  parameter int WORDS = WORDS_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] imem_addr,
  output logic [31:0] iin,
  output logic        stall,
  input  logic        inv,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_data
);
  localparam int OW = $clog2(WORDS);
  localparam int IW = $clog2(LINES);
  localparam int TW = 30 - OW - IW;
  localparam int LW = 30 - OW;
  logic [LINES-1:0] valid;
  logic [TW-1:0] tags [LINES];
  logic [31:0] data [LINES*WORDS];
  logic idle, we, last, set_valid, hit, unused_bits;
  logic [LW-1:0] wr_line;
  logic [OW-1:0] wr_off, off;
  logic [IW-1:0] idx;
  logic [TW-1:0] tag;
  assign off = imem_addr[2 +: OW];
  assign idx = imem_addr[2+OW +: IW];
  assign tag = imem_addr[31 -: TW];
  assign unused_bits = ^imem_addr[1:0];
  assign hit = idle && valid[idx] && tags[idx] == tag;
  // during reset the fetch stage must see a free-running nop, not a stall
  assign stall = rst && !hit;
  assign iin = hit ? data[{idx, off}] : NOP;
  cpu_icache_fill #(.WORDS(WORDS)) u_fill (
    .clk(clk),
    .rst(rst),
    .miss(!hit),
    .inv(inv),
    .mem_ack(mem_ack),
    .line(imem_addr[31:2+OW]),
    .idle(idle),
    .we(we),
    .last(last),
    .set_valid(set_valid),
    .mem_req(mem_req),
    .mem_addr(mem_addr),
    .wr_line(wr_line),
    .wr_off(wr_off)
  );
  always_ff @(posedge clk or negedge rst)
    if (!rst) valid <= '0;
    else begin
      if (inv) valid <= '0;
      if (set_valid) valid[wr_line[IW-1:0]] <= 1'b1;
    end
  always_ff @(posedge clk) begin
    if (we) data[{wr_line[IW-1:0], wr_off}] <= mem_data;
    if (last) tags[wr_line[IW-1:0]] <= wr_line[LW-1:IW];
  end
endmodule

// File: tb/tb_cpu_icache.sv
// tb_cpu_icache: randomized self-checking bench against a line-address model of the cache
module tb_cpu_icache;
  logic clk = 1'b0, rst = 1'b1, inv = 1'b0, mem_ack = 1'b0;
  logic mem_req, stall;
  logic [31:0] imem_addr = 32'h0, iin, mem_addr, mem_data;
  int checks = 0, errors = 0, period = 1, wc = 0;
  logic [31:0] acked [$];
  bit mv [16];
  logic [31:0] mbase [16];

  assign mem_data = 32'h1000_0000 + mem_addr;
  always #5 clk = ~clk;

  cpu_icache #(.LINES(16), .WORDS(4)) dut (
    .clk(clk), .rst(rst), .imem_addr(imem_addr), .iin(iin), .stall(stall), .inv(inv),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_data(mem_data)
  );

  // memory responder: ack every period-th cycle of a request, or random bits when period is 0
  always @(negedge clk) begin
    wc = mem_req ? wc + 1 : 0;
    mem_ack = period == 0 ? 1'($urandom) : (mem_req && wc % period == 0);
    #4;
    if (mem_req && mem_ack) acked.push_back(mem_addr);
  end

  task automatic clear_model;
    foreach (mv[i]) mv[i] = 1'b0;
  endtask

  task automatic access(input logic [31:0] a, input string name);
    logic [31:0] b = a & ~32'hF;
    int i = int'((a >> 4) & 32'hF);
    bit exp_hit = mv[i] && mbase[i] == b;
    int n = 0;
    bit ok;
    acked.delete();
    imem_addr = a;
    #1;
    checks++;
    if (stall !== !exp_hit) begin
      errors++;
      $display("FAIL %s lookup stall=%b expected %b", name, stall, !exp_hit);
    end
    if (exp_hit) begin
      checks++;
      if (mem_req !== 1'b0) begin
        errors++;
        $display("FAIL %s hit mem_req=%b expected 0", name, mem_req);
      end
    end
    while (stall === 1'b1 && n < 400) begin
      n++;
      @(negedge clk);
      #1;
    end
    checks++;
    if (stall !== 1'b0) begin
      errors++;
      $display("FAIL %s timeout stall=%b expected 0", name, stall);
    end
    if (!exp_hit && period != 0) begin
      checks++;
      if (n != 1 + 4 * period) begin
        errors++;
        $display("FAIL %s stall_cycles got %0d expected %0d", name, n, 1 + 4 * period);
      end
    end
    ok = acked.size() == (exp_hit ? 0 : 4);
    for (int k = 0; ok && k < acked.size(); k++) ok = acked[k] == b + 32'(4 * k);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s fill_addrs got %0d words first %h expected %0d words from %h", name,
               acked.size(), acked.size() > 0 ? acked[0] : 32'h0, exp_hit ? 0 : 4, b);
    end
    checks++;
    if (iin !== 32'h1000_0000 + (a & ~32'h3)) begin
      errors++;
      $display("FAIL %s iin got %h expected %h", name, iin, 32'h1000_0000 + (a & ~32'h3));
    end
    mv[i] = 1'b1;
    mbase[i] = b;
  endtask

  task automatic test_reset;
    #1 rst = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks += 4;
    if (stall !== 1'b0) begin errors++; $display("FAIL reset stall=%b expected 0", stall); end
    if (iin !== 32'h0) begin errors++; $display("FAIL reset iin=%h expected 0", iin); end
    if (mem_req !== 1'b0) begin errors++; $display("FAIL reset mem_req=%b expected 0", mem_req); end
    if (mem_addr !== 32'h0) begin errors++; $display("FAIL reset mem_addr=%h expected 0", mem_addr); end
    rst = 1'b1;
    clear_model();
  endtask

  task automatic test_first_fill;
    period = 1;
    access(32'h0, "first_fill");
  endtask

  task automatic test_hit;
    access(32'h4, "hit_same_line");
  endtask

  task automatic test_conflict;
    access(32'h100, "conflict_new_tag");
    access(32'h0, "conflict_back");
  endtask

  task automatic test_wait_states;
    period = 3;
    access(32'h20, "wait_states");
    period = 1;
  endtask

  task automatic test_wrap;
    access(32'hFFFF_FFFC, "top_of_memory");
  endtask

  task automatic test_inv;
    int n = 0;
    bit ok;
    acked.delete();
    imem_addr = 32'h40;
    #1;
    checks++;
    if (stall !== 1'b1) begin errors++; $display("FAIL inv_start stall=%b expected 1", stall); end
    @(negedge clk);
    @(negedge clk);
    inv = 1'b1;
    @(negedge clk);
    inv = 1'b0;
    #1;
    while (stall === 1'b1 && n < 400) begin
      n++;
      @(negedge clk);
      #1;
    end
    ok = acked.size() == 8;
    for (int k = 0; ok && k < 8; k++) ok = acked[k] == 32'h40 + 32'(4 * (k % 4));
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL inv_refill got %0d words expected 8 (two fills of 0x40)", acked.size());
    end
    checks++;
    if (iin !== 32'h1000_0040) begin
      errors++;
      $display("FAIL inv_data iin got %h expected %h", iin, 32'h1000_0040);
    end
    clear_model();
    mv[4] = 1'b1;
    mbase[4] = 32'h40;
    access(32'h0, "after_inv");
  endtask

  task automatic test_reset_mid_fill;
    imem_addr = 32'h3C0;
    #1;
    checks++;
    if (stall !== 1'b1) begin errors++; $display("FAIL rst_start stall=%b expected 1", stall); end
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    checks += 3;
    if (mem_req !== 1'b0) begin errors++; $display("FAIL rst_mid mem_req=%b expected 0", mem_req); end
    if (stall !== 1'b0) begin errors++; $display("FAIL rst_mid stall=%b expected 0", stall); end
    if (iin !== 32'h0) begin errors++; $display("FAIL rst_mid iin=%h expected 0", iin); end
    imem_addr = 32'h0;
    @(negedge clk);
    #1;
    rst = 1'b1;
    clear_model();
    access(32'h0, "after_reset");
  endtask

  task automatic test_random;
    for (int it = 0; it < 80; it++) begin
      period = $urandom_range(0, 3);
      if ($urandom_range(0, 7) == 0) begin
        inv = 1'b1;
        @(negedge clk);
        inv = 1'b0;
        #1;
        clear_model();
      end
      access(32'($urandom_range(0, 767)), "random");
    end
    period = 1;
  endtask

  initial begin
    test_reset();
    test_first_fill();
    test_hit();
    test_conflict();
    test_wait_states();
    test_wrap();
    test_inv();
    test_reset_mid_fill();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
